// File: rtl/riscv_dmem_chk_pkg.sv
// Shared types for the data-memory write checker: FSM states, table entry kinds, verdict codes.
package riscv_dmem_chk_pkg;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;
    typedef enum logic [1:0] {K_NONE = 2'd0, K_TERMINAL = 2'd1, K_ALLOW = 2'd2} kind_e;
    typedef enum logic [1:0] {F_NONE, F_UNEXPECTED, F_MISMATCH, F_TIMEOUT} fail_e;

    // Width of an index into n slots, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The unused encoding 3 behaves as an empty slot.
    function automatic kind_e to_kind(input logic [1:0] k);
        case (k)
            2'd1:    return K_TERMINAL;
            2'd2:    return K_ALLOW;
            default: return K_NONE;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_chk_trace_buf.sv
// Ring of the most recent monitored writes; read index 0 is the newest entry.
// P_DEPTH must be a power of two, at least 2, so the write pointer wraps by overflow.
module riscv_dmem_chk_trace_buf
    import riscv_dmem_chk_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_DEPTH      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [P_ADDR_WIDTH-1:0]       i_addr,
    input  logic [P_DATA_WIDTH-1:0]       i_data,
    input  logic [idx_w(P_DEPTH)-1:0]     i_rd_idx,
    output logic [P_ADDR_WIDTH-1:0]       o_rd_addr,
    output logic [P_DATA_WIDTH-1:0]       o_rd_data
);

    localparam int LP_PTR_W = idx_w(P_DEPTH);
    localparam logic [LP_PTR_W:0] LP_FULL = (LP_PTR_W + 1)'(P_DEPTH);

    logic [P_ADDR_WIDTH-1:0] r_addr [P_DEPTH];
    logic [P_DATA_WIDTH-1:0] r_data [P_DEPTH];
    logic [LP_PTR_W-1:0]     r_wptr;
    logic [LP_PTR_W:0]       r_fill;
    logic [LP_PTR_W-1:0]     w_slot;
    logic                    w_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_push) begin
            r_wptr <= r_wptr + 1'b1;
            if (r_fill != LP_FULL)
                r_fill <= r_fill + 1'b1;
        end
    end

    // Storage is gated by r_fill on read, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_wptr] <= i_addr;
            r_data[r_wptr] <= i_data;
        end
    end

    assign w_slot    = r_wptr - 1'b1 - i_rd_idx;
    assign w_valid   = ({1'b0, i_rd_idx} < r_fill);
    assign o_rd_addr = w_valid ? r_addr[w_slot] : '0;
    assign o_rd_data = w_valid ? r_data[w_slot] : '0;

endmodule

// File: rtl/riscv_dmem_write_checker.sv
// Pass/fail monitor on the dmem write bus against a programmable table of expected writes.
// Optional write trace ring built only when DMEM_CHK_TRACE_EN is defined.
module riscv_dmem_write_checker
    import riscv_dmem_chk_pkg::*;
#(
    parameter int P_DATA_WIDTH     = 32,
    parameter int P_ADDR_WIDTH     = 8,
    parameter int P_NUM_ENTRIES    = 4,
    parameter int P_TIMEOUT_CYCLES = 5000,
    parameter int P_CNT_WIDTH      = 16,
    parameter int P_TRACE_DEPTH    = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_cfg_we,
    input  logic [idx_w(P_NUM_ENTRIES)-1:0] i_cfg_idx,
    input  logic [1:0]                      i_cfg_kind,
    input  logic [P_ADDR_WIDTH-1:0]         i_cfg_addr,
    input  logic [P_DATA_WIDTH-1:0]         i_cfg_data,
    input  logic                            i_dmem_we,
    input  logic [P_ADDR_WIDTH-1:0]         i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]         i_dmem_wdata,
    output logic                            o_done,
    output logic                            o_pass,
    output logic [1:0]                      o_fail_code,
    output logic [P_ADDR_WIDTH-1:0]         o_fail_addr,
    output logic [P_DATA_WIDTH-1:0]         o_fail_data,
    output logic [P_CNT_WIDTH-1:0]          o_cycle_count,
    output logic [P_CNT_WIDTH-1:0]          o_write_count,
    input  logic [idx_w(P_TRACE_DEPTH)-1:0] i_trace_idx,
    output logic [P_ADDR_WIDTH-1:0]         o_trace_addr,
    output logic [P_DATA_WIDTH-1:0]         o_trace_data
);

    localparam int LP_IDX_W = idx_w(P_NUM_ENTRIES);
    localparam logic [LP_IDX_W:0]      LP_NUM     = (LP_IDX_W + 1)'(P_NUM_ENTRIES);
    localparam logic [P_CNT_WIDTH-1:0] LP_TO_LAST = P_CNT_WIDTH'(P_TIMEOUT_CYCLES - 1);

    typedef struct packed {
        kind_e                   kind;
        logic [P_ADDR_WIDTH-1:0] addr;
        logic [P_DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                  r_tbl [P_NUM_ENTRIES];
    state_e                  r_state, w_state_nxt;
    fail_e                   r_fail_code, w_fail_nxt;
    logic [P_ADDR_WIDTH-1:0] r_fail_addr;
    logic [P_DATA_WIDTH-1:0] r_fail_data;
    logic [P_CNT_WIDTH-1:0]  r_cyc, r_wcnt;
    logic                    w_wr_run, w_term_hit, w_term_addr, w_allow_hit, w_timeout;

    assign w_wr_run  = (r_state == S_RUN) && i_dmem_we;
    assign w_timeout = (r_cyc == LP_TO_LAST);

    // Order of the table does not change the outcome, so a flat OR-reduce is enough.
    always_comb begin
        w_term_hit  = 1'b0;
        w_term_addr = 1'b0;
        w_allow_hit = 1'b0;
        for (int i = 0; i < P_NUM_ENTRIES; i++) begin
            if (r_tbl[i].addr == i_dmem_addr) begin
                if (r_tbl[i].kind == K_TERMINAL) begin
                    w_term_addr = 1'b1;
                    if (r_tbl[i].data == i_dmem_wdata)
                        w_term_hit = 1'b1;
                end
                if (r_tbl[i].kind == K_ALLOW)
                    w_allow_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A deciding write outranks the timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = F_NONE;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_wr_run && w_term_hit) begin
                    w_state_nxt = S_PASS;
                end else if (w_wr_run && !w_allow_hit) begin
                    w_state_nxt = S_FAIL;
                    w_fail_nxt  = w_term_addr ? F_MISMATCH : F_UNEXPECTED;
                end else if (w_timeout) begin
                    w_state_nxt = S_TIMEOUT;
                    w_fail_nxt  = F_TIMEOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < P_NUM_ENTRIES; i++)
                r_tbl[i] <= '{kind: K_NONE, addr: '0, data: '0};
            r_cyc       <= '0;
            r_wcnt      <= '0;
            r_fail_code <= F_NONE;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            if (r_state == S_IDLE && i_cfg_we && ({1'b0, i_cfg_idx} < LP_NUM))
                r_tbl[i_cfg_idx] <= '{kind: to_kind(i_cfg_kind), addr: i_cfg_addr, data: i_cfg_data};
            if (r_state == S_RUN) begin
                if (r_cyc != '1)
                    r_cyc <= r_cyc + 1'b1;
                if (i_dmem_we && r_wcnt != '1)
                    r_wcnt <= r_wcnt + 1'b1;
                r_fail_code <= w_fail_nxt;
                if (w_state_nxt == S_FAIL) begin
                    r_fail_addr <= i_dmem_addr;
                    r_fail_data <= i_dmem_wdata;
                end
            end
        end
    end

    assign o_done        = (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TIMEOUT);
    assign o_pass        = (r_state == S_PASS);
    assign o_fail_code   = r_fail_code;
    assign o_fail_addr   = r_fail_addr;
    assign o_fail_data   = r_fail_data;
    assign o_cycle_count = r_cyc;
    assign o_write_count = r_wcnt;

`ifdef DMEM_CHK_TRACE_EN
    riscv_dmem_chk_trace_buf #(
        .P_ADDR_WIDTH (P_ADDR_WIDTH),
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_DEPTH      (P_TRACE_DEPTH)
    ) u_trace (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (w_wr_run),
        .i_addr    (i_dmem_addr),
        .i_data    (i_dmem_wdata),
        .i_rd_idx  (i_trace_idx),
        .o_rd_addr (o_trace_addr),
        .o_rd_data (o_trace_data)
    );
`else
    logic w_unused_trace_idx;
    assign w_unused_trace_idx = ^i_trace_idx;
    assign o_trace_addr       = '0;
    assign o_trace_data       = '0;
`endif

endmodule

// File: tb/tb_riscv_dmem_write_checker.sv
// Scenario bench for riscv_dmem_write_checker: expected verdicts are queued when stimulus is driven
// and popped when the verdict appears.
module tb_riscv_dmem_write_checker;

    localparam int A  = 8;
    localparam int D  = 32;
    localparam int C  = 16;
    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         i_rst, i_start, i_cfg_we, i_dmem_we;
    logic [1:0]   i_cfg_idx, i_cfg_kind;
    logic [A-1:0] i_cfg_addr, i_dmem_addr;
    logic [D-1:0] i_cfg_data, i_dmem_wdata;
    logic [2:0]   i_trace_idx;
    logic         o_done, o_pass;
    logic [1:0]   o_fail_code;
    logic [A-1:0] o_fail_addr, o_trace_addr;
    logic [D-1:0] o_fail_data, o_trace_data;
    logic [C-1:0] o_cycle_count, o_write_count;

    always #5 clk = ~clk;

    riscv_dmem_write_checker #(
        .P_DATA_WIDTH(D), .P_ADDR_WIDTH(A), .P_NUM_ENTRIES(4),
        .P_TIMEOUT_CYCLES(TO), .P_CNT_WIDTH(C), .P_TRACE_DEPTH(8)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_cfg_we(i_cfg_we),
        .i_cfg_idx(i_cfg_idx), .i_cfg_kind(i_cfg_kind), .i_cfg_addr(i_cfg_addr),
        .i_cfg_data(i_cfg_data), .i_dmem_we(i_dmem_we), .i_dmem_addr(i_dmem_addr),
        .i_dmem_wdata(i_dmem_wdata), .o_done(o_done), .o_pass(o_pass),
        .o_fail_code(o_fail_code), .o_fail_addr(o_fail_addr), .o_fail_data(o_fail_data),
        .o_cycle_count(o_cycle_count), .o_write_count(o_write_count),
        .i_trace_idx(i_trace_idx), .o_trace_addr(o_trace_addr), .o_trace_data(o_trace_data)
    );

    typedef struct packed {
        logic         done;
        logic         pass;
        logic [1:0]   code;
        logic [A-1:0] addr;
        logic [D-1:0] data;
        logic [C-1:0] wcnt;
        logic [C-1:0] ccnt;
    } verdict_t;

    verdict_t sb[$];
    verdict_t e, a;
    int n_vec = 0;
    int n_err = 0;

    function automatic verdict_t mk(input logic dn, input logic ps, input logic [1:0] cd,
                                    input int ad, input int dt, input int wc, input int cc);
        verdict_t v;
        v.done = dn; v.pass = ps; v.code = cd;
        v.addr = A'(ad); v.data = D'(dt); v.wcnt = C'(wc); v.ccnt = C'(cc);
        return v;
    endfunction

    function automatic verdict_t observe();
        verdict_t v;
        v.done = o_done; v.pass = o_pass; v.code = o_fail_code;
        v.addr = o_fail_addr; v.data = o_fail_data;
        v.wcnt = o_write_count; v.ccnt = o_cycle_count;
        return v;
    endfunction

    function automatic string fmt(input verdict_t v);
        return $sformatf("done=%0d pass=%0d code=%0d addr=%0d data=%0d wc=%0d cc=%0d",
                         v.done, v.pass, v.code, v.addr, v.data, v.wcnt, v.ccnt);
    endfunction

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_start = 1'b0; i_cfg_we = 1'b0; i_dmem_we = 1'b0;
        i_cfg_idx = '0; i_cfg_kind = '0; i_cfg_addr = '0; i_cfg_data = '0;
        i_dmem_addr = '0; i_dmem_wdata = '0; i_trace_idx = '0;
        step(); step();
        i_rst = 1'b0;
    endtask

    task automatic cfg(input int idx, input int kind, input int ad, input int dt);
        i_cfg_we = 1'b1; i_cfg_idx = 2'(idx); i_cfg_kind = 2'(kind);
        i_cfg_addr = A'(ad); i_cfg_data = D'(dt);
        step();
        i_cfg_we = 1'b0;
    endtask

    task automatic start();
        i_start = 1'b1; step(); i_start = 1'b0;
    endtask

    task automatic wr(input int ad, input int dt);
        i_dmem_we = 1'b1; i_dmem_addr = A'(ad); i_dmem_wdata = D'(dt);
        step();
        i_dmem_we = 1'b0;
    endtask

    task automatic prog_std();
        cfg(0, 1, 100, 25);
        cfg(1, 2, 96, 0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b1; i_dmem_we = 1'b1; i_dmem_addr = 8'd64;
        step(); step();
        do_reset();
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL reset: got %s want %s", fmt(a), fmt(e)); end
        n_vec++;
        if ({o_trace_addr, o_trace_data} !== '0) begin
            n_err++; $display("FAIL reset_trace: got %0d/%0d want 0/0", o_trace_addr, o_trace_data);
        end
    endtask

    task automatic test_pass();
        do_reset(); prog_std(); start();
        wr(96, 7);
        n_vec++;
        if (o_done !== 1'b0) begin n_err++; $display("FAIL t1_allow: done=%0d want 0", o_done); end
        sb.push_back(mk(1, 1, 0, 0, 0, 2, 2));
        wr(100, 25);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t1_pass: got %s want %s", fmt(a), fmt(e)); end
        sb.push_back(e);
        i_start = 1'b1;
        wr(64, 3); wr(100, 15); step();
        i_start = 1'b0;
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t1_hold: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_fail();
        do_reset(); prog_std(); start();
        sb.push_back(mk(1, 0, 2, 100, 15, 1, 1));
        wr(100, 15);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t2_mismatch: got %s want %s", fmt(a), fmt(e)); end
        do_reset(); prog_std(); start();
        sb.push_back(mk(1, 0, 1, 64, 1, 1, 1));
        wr(64, 1);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t3_unexpected: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_priority();
        do_reset(); cfg(0, 1, 100, 25); cfg(1, 2, 100, 0); start();
        wr(100, 15);
        n_vec++;
        if (o_done !== 1'b0) begin n_err++; $display("FAIL allow_over_mismatch: done=%0d want 0", o_done); end
        sb.push_back(mk(1, 1, 0, 0, 0, 2, 2));
        wr(100, 25);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL terminal_over_allow: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset(); prog_std(); start();
        sb.push_back(mk(1, 0, 3, 0, 0, 0, TO));
        cnt = 0;
        while (cnt < 4 * TO && o_done !== 1'b1) begin step(); cnt++; end
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t4_timeout: got %s want %s", fmt(a), fmt(e)); end
        n_vec++;
        if (cnt !== TO) begin n_err++; $display("FAIL t4_latency: got %0d cycles want %0d", cnt, TO); end

        do_reset(); prog_std(); start();
        repeat (TO - 1) step();
        n_vec++;
        if (o_done !== 1'b0) begin n_err++; $display("FAIL t4_early: done=%0d want 0", o_done); end
        sb.push_back(mk(1, 1, 0, 0, 0, 1, TO));
        wr(100, 25);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t4_pass_wins: got %s want %s", fmt(a), fmt(e)); end

        do_reset(); prog_std(); start();
        repeat (TO - 1) step();
        sb.push_back(mk(1, 0, 2, 100, 15, 1, TO));
        wr(100, 15);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t4_fail_wins: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_rst_mid_run();
        do_reset(); prog_std(); start();
        wr(96, 1); wr(96, 2); wr(96, 3);
        i_rst = 1'b1; step(); i_rst = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t5_cleared: got %s want %s", fmt(a), fmt(e)); end
        start();
        sb.push_back(mk(1, 0, 1, 100, 25, 1, 1));
        wr(100, 25);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL t5_unprogrammed: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_cfg_edges();
        do_reset();
        i_start = 1'b1; cfg(0, 1, 100, 25); i_start = 1'b0;
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 1));
        wr(100, 25);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL cfg_with_start: got %s want %s", fmt(a), fmt(e)); end

        do_reset();
        i_start = 1'b1; cfg(0, 1, 100, 25); i_start = 1'b0;
        cfg(1, 2, 64, 0);
        sb.push_back(mk(1, 0, 1, 64, 9, 1, 2));
        wr(64, 9);
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL cfg_in_run: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_back_to_back();
        do_reset(); prog_std();
        i_dmem_we = 1'b1; i_dmem_addr = 8'd64; i_dmem_wdata = 32'd1;
        step(); step(); step();
        i_dmem_we = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL idle_ignores_writes: got %s want %s", fmt(a), fmt(e)); end
        start();
        i_dmem_we = 1'b1; i_dmem_addr = 8'd96;
        for (int i = 0; i < 5; i++) begin i_dmem_wdata = D'(i); step(); end
        sb.push_back(mk(1, 1, 0, 0, 0, 6, 6));
        i_dmem_addr = 8'd100; i_dmem_wdata = 32'd25;
        step();
        i_dmem_we = 1'b0;
        e = sb.pop_front(); a = observe(); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL back_to_back: got %s want %s", fmt(a), fmt(e)); end
    endtask

    task automatic test_trace();
`ifdef DMEM_CHK_TRACE_EN
        logic [A+D-1:0] hist[$];
        logic [A+D-1:0] want;
        do_reset();
        for (int k = 0; k < 4; k++) cfg(k, 2, 96 + k, 0);
        start();
        for (int i = 0; i < 10; i++) begin
            wr(96 + (i % 4), i + 1);
            hist.push_back({A'(96 + (i % 4)), D'(i + 1)});
            if (i == 2) begin
                i_trace_idx = 3'd3; #1;
                n_vec++;
                if ({o_trace_addr, o_trace_data} !== '0) begin
                    n_err++; $display("FAIL trace_past_fill: got %0d/%0d want 0/0", o_trace_addr, o_trace_data);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            i_trace_idx = 3'(k); #1;
            want = hist[hist.size() - 1 - k];
            n_vec++;
            if ({o_trace_addr, o_trace_data} !== want) begin
                n_err++; $display("FAIL trace_idx%0d: got %0d/%0d want %0d/%0d", k,
                                  o_trace_addr, o_trace_data, want[A+D-1:D], want[D-1:0]);
            end
        end
`else
        do_reset(); prog_std(); start();
        wr(96, 7); wr(96, 8);
        for (int k = 0; k < 8; k++) begin
            i_trace_idx = 3'(k); #1;
            n_vec++;
            if ({o_trace_addr, o_trace_data} !== '0) begin
                n_err++; $display("FAIL trace_tied_idx%0d: got %0d/%0d want 0/0", k, o_trace_addr, o_trace_data);
            end
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_priority();
        test_timeout();
        test_rst_mid_run();
        test_cfg_edges();
        test_back_to_back();
        test_trace();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
